// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the hardwired control sequencer: opcodes, step states,
// the strobe bundle and the last-step table per opcode.
package cpu_ctrl_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        ST_RESET,
        ST_T0,
        ST_T1,
        ST_T2,
        ST_T3,
        ST_T4,
        ST_T5,
        ST_T6,
        ST_T7,
        ST_HALT
    } state_t;

    typedef struct packed {
        logic pc_out;
        logic zhigh_out;
        logic zlow_out;
        logic mdr_out;
        logic mar_in;
        logic z_in;
        logic pc_in;
        logic mdr_in;
        logic ir_in;
        logic y_in;
        logic inc_pc;
        logic read;
        logic write;
        logic gra;
        logic grb;
        logic grc;
        logic r_in;
        logic r_out;
        logic ba_out;
        logic c_out;
        logic con_in;
        logic alu_add;
        logic alu_sub;
        logic alu_and;
        logic alu_or;
        logic run;
    } ctrl_t;

    // Undefined opcodes behave like nop, so they finish at T3.
    function automatic state_t last_step(input logic [4:0] op);
        case (op)
            OP_LD, OP_ST:                                    last_step = ST_T7;
            OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: last_step = ST_T5;
            OP_BR:                                           last_step = ST_T6;
            default:                                         last_step = ST_T3;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational strobe decode: maps the current step, opcode and branch
// condition onto the full set of datapath control strobes.
module ctrl_decode
    import cpu_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [4:0] opcode,
    input  logic       con_ff,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        ctrl.run = (state != ST_RESET) && (state != ST_HALT);
        case (state)
            ST_T0: begin
                ctrl.pc_out = 1'b1;
                ctrl.mar_in = 1'b1;
                ctrl.inc_pc = 1'b1;
                ctrl.z_in   = 1'b1;
            end
            ST_T1: begin
                ctrl.zlow_out = 1'b1;
                ctrl.pc_in    = 1'b1;
                ctrl.read     = 1'b1;
                ctrl.mdr_in   = 1'b1;
            end
            ST_T2: begin
                ctrl.mdr_out = 1'b1;
                ctrl.ir_in   = 1'b1;
            end
            ST_T3: begin
                case (opcode)
                    OP_LD, OP_LDI, OP_ST: begin
                        ctrl.grb    = 1'b1;
                        ctrl.ba_out = 1'b1;
                        ctrl.y_in   = 1'b1;
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: begin
                        ctrl.grb   = 1'b1;
                        ctrl.r_out = 1'b1;
                        ctrl.y_in  = 1'b1;
                    end
                    OP_BR: begin
                        ctrl.gra    = 1'b1;
                        ctrl.r_out  = 1'b1;
                        ctrl.con_in = 1'b1;
                    end
                    OP_JR: begin
                        ctrl.gra   = 1'b1;
                        ctrl.r_out = 1'b1;
                        ctrl.pc_in = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T4: begin
                case (opcode)
                    OP_LD, OP_LDI, OP_ST, OP_ADDI: begin
                        ctrl.c_out   = 1'b1;
                        ctrl.alu_add = 1'b1;
                        ctrl.z_in    = 1'b1;
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                        ctrl.grc     = 1'b1;
                        ctrl.r_out   = 1'b1;
                        ctrl.z_in    = 1'b1;
                        ctrl.alu_add = (opcode == OP_ADD);
                        ctrl.alu_sub = (opcode == OP_SUB);
                        ctrl.alu_and = (opcode == OP_AND);
                        ctrl.alu_or  = (opcode == OP_OR);
                    end
                    OP_BR: begin
                        ctrl.pc_out = 1'b1;
                        ctrl.y_in   = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T5: begin
                case (opcode)
                    OP_LD, OP_ST: begin
                        ctrl.zlow_out = 1'b1;
                        ctrl.mar_in   = 1'b1;
                    end
                    OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: begin
                        ctrl.zlow_out = 1'b1;
                        ctrl.gra      = 1'b1;
                        ctrl.r_in     = 1'b1;
                    end
                    OP_BR: begin
                        ctrl.c_out   = 1'b1;
                        ctrl.alu_add = 1'b1;
                        ctrl.z_in    = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T6: begin
                case (opcode)
                    OP_LD: begin
                        ctrl.read   = 1'b1;
                        ctrl.mdr_in = 1'b1;
                    end
                    OP_ST: begin
                        ctrl.gra    = 1'b1;
                        ctrl.r_out  = 1'b1;
                        ctrl.mdr_in = 1'b1;
                    end
                    // The branch target is only loaded when the condition holds.
                    OP_BR: begin
                        ctrl.zlow_out = 1'b1;
                        ctrl.pc_in    = con_ff;
                    end
                    default: ;
                endcase
            end
            ST_T7: begin
                case (opcode)
                    OP_LD: begin
                        ctrl.mdr_out = 1'b1;
                        ctrl.gra     = 1'b1;
                        ctrl.r_in    = 1'b1;
                    end
                    OP_ST: ctrl.write = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Step sequencer for the CPU datapath: owns the step register, memory-wait
// stalls and halt handling, and exposes the decoded strobes.
module control_unit
    import cpu_ctrl_pkg::*;
(
    input  logic        Clock,
    input  logic        Clear,
    input  logic [31:0] IR,
    input  logic        CON_FF,
    input  logic        Mem_ready,
    input  logic        Stop,
    output logic        PCout,
    output logic        Zhighout,
    output logic        Zlowout,
    output logic        MDRout,
    output logic        MARin,
    output logic        Zin,
    output logic        PCin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        IncPC,
    output logic        Read,
    output logic        Write,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        Cout,
    output logic        CONIn,
    output logic        ADD,
    output logic        SUB,
    output logic        AND,
    output logic        OR,
    output logic        Run
);

    state_t     state_q;
    state_t     state_d;
    logic [4:0] opcode;
    logic       mem_wait;
    logic       instr_end;
    logic       unused_ir;
    ctrl_t      ctrl;

    assign opcode    = IR[31:27];
    assign unused_ir = ^IR[26:0];

    // Fetch-time states never consult the opcode; the last-step table only
    // yields T3..T7, so it cannot match during T0..T2.
    always_comb begin
        mem_wait  = (state_q == ST_T1)
                 || ((state_q == ST_T6) && (opcode == OP_LD))
                 || ((state_q == ST_T7) && (opcode == OP_ST));
        instr_end = (state_q == last_step(opcode));
        state_d   = state_q;
        case (state_q)
            ST_RESET: state_d = ST_T0;
            ST_HALT:  state_d = ST_HALT;
            default: begin
                if (mem_wait && !Mem_ready) begin
                    state_d = state_q;
                end else if ((state_q == ST_T3) && (opcode == OP_HALT)) begin
                    state_d = ST_HALT;
                end else if (instr_end) begin
                    state_d = Stop ? ST_HALT : ST_T0;
                end else begin
                    state_d = state_t'(4'(state_q) + 4'd1);
                end
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Clear) begin
            state_q <= ST_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    ctrl_decode u_decode (
        .state  (state_q),
        .opcode (opcode),
        .con_ff (CON_FF),
        .ctrl   (ctrl)
    );

    assign PCout    = ctrl.pc_out;
    assign Zhighout = ctrl.zhigh_out;
    assign Zlowout  = ctrl.zlow_out;
    assign MDRout   = ctrl.mdr_out;
    assign MARin    = ctrl.mar_in;
    assign Zin      = ctrl.z_in;
    assign PCin     = ctrl.pc_in;
    assign MDRin    = ctrl.mdr_in;
    assign IRin     = ctrl.ir_in;
    assign Yin      = ctrl.y_in;
    assign IncPC    = ctrl.inc_pc;
    assign Read     = ctrl.read;
    assign Write    = ctrl.write;
    assign Gra      = ctrl.gra;
    assign Grb      = ctrl.grb;
    assign Grc      = ctrl.grc;
    assign Rin      = ctrl.r_in;
    assign Rout     = ctrl.r_out;
    assign BAout    = ctrl.ba_out;
    assign Cout     = ctrl.c_out;
    assign CONIn    = ctrl.con_in;
    assign ADD      = ctrl.alu_add;
    assign SUB      = ctrl.alu_sub;
    assign AND      = ctrl.alu_and;
    assign OR       = ctrl.alu_or;
    assign Run      = ctrl.run;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: each instruction is expanded into a list of
// expected strobe sets per step and replayed cycle by cycle against the DUT.
module tb_control_unit;

    logic        Clock = 1'b0;
    logic        Clear = 1'b0;
    logic [31:0] IR = '0;
    logic        CON_FF = 1'b0;
    logic        Mem_ready = 1'b1;
    logic        Stop = 1'b0;
    logic PCout, Zhighout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin;
    logic IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONIn;
    logic ADD, SUB, AND, OR, Run;

    int tests_run = 0;
    int tests_failed = 0;

    localparam logic [25:0] B_OR    = 26'd1 << 0;
    localparam logic [25:0] B_AND   = 26'd1 << 1;
    localparam logic [25:0] B_SUB   = 26'd1 << 2;
    localparam logic [25:0] B_ADD   = 26'd1 << 3;
    localparam logic [25:0] B_CONIN = 26'd1 << 4;
    localparam logic [25:0] B_COUT  = 26'd1 << 5;
    localparam logic [25:0] B_BAOUT = 26'd1 << 6;
    localparam logic [25:0] B_ROUT  = 26'd1 << 7;
    localparam logic [25:0] B_RIN   = 26'd1 << 8;
    localparam logic [25:0] B_GRC   = 26'd1 << 9;
    localparam logic [25:0] B_GRB   = 26'd1 << 10;
    localparam logic [25:0] B_GRA   = 26'd1 << 11;
    localparam logic [25:0] B_WRITE = 26'd1 << 12;
    localparam logic [25:0] B_READ  = 26'd1 << 13;
    localparam logic [25:0] B_INCPC = 26'd1 << 14;
    localparam logic [25:0] B_YIN   = 26'd1 << 15;
    localparam logic [25:0] B_IRIN  = 26'd1 << 16;
    localparam logic [25:0] B_MDRIN = 26'd1 << 17;
    localparam logic [25:0] B_PCIN  = 26'd1 << 18;
    localparam logic [25:0] B_ZIN   = 26'd1 << 19;
    localparam logic [25:0] B_MARIN = 26'd1 << 20;
    localparam logic [25:0] B_MDROUT= 26'd1 << 21;
    localparam logic [25:0] B_ZLOW  = 26'd1 << 22;
    localparam logic [25:0] B_ZHIGH = 26'd1 << 23;
    localparam logic [25:0] B_PCOUT = 26'd1 << 24;
    localparam logic [25:0] B_RUN   = 26'd1 << 25;

    logic [25:0] obs;
    assign obs = {Run, PCout, Zhighout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin,
                  Yin, IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONIn,
                  ADD, SUB, AND, OR};

    typedef struct {
        logic [25:0] mask;
        bit          wait_step;
        bit          cond_pc;
    } step_t;

    step_t plan[$];

    logic [4:0] op_list [14] = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100,
                                 5'b00101, 5'b00110, 5'b01100, 5'b10010, 5'b10100,
                                 5'b11010, 5'b11011, 5'b01000, 5'b11111};

    control_unit dut (
        .Clock(Clock), .Clear(Clear), .IR(IR), .CON_FF(CON_FF), .Mem_ready(Mem_ready),
        .Stop(Stop), .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout),
        .MDRout(MDRout), .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin),
        .IRin(IRin), .Yin(Yin), .IncPC(IncPC), .Read(Read), .Write(Write),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .Cout(Cout), .CONIn(CONIn), .ADD(ADD), .SUB(SUB), .AND(AND), .OR(OR), .Run(Run)
    );

    always #5 Clock = ~Clock;

    task automatic checkOutput(input string tag, input logic [25:0] expected);
        tests_run++;
        assert (obs === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expected);
        end
    endtask

    task automatic addStep(input logic [25:0] m, input bit w, input bit c);
        step_t s;
        s.mask = m | B_RUN;
        s.wait_step = w;
        s.cond_pc = c;
        plan.push_back(s);
    endtask

    // Expected strobe list for one instruction, fetch included.
    task automatic buildPlan(input logic [4:0] op);
        logic [25:0] alu;
        plan.delete();
        addStep(B_PCOUT | B_MARIN | B_INCPC | B_ZIN, 0, 0);
        addStep(B_ZLOW | B_PCIN | B_READ | B_MDRIN, 1, 0);
        addStep(B_MDROUT | B_IRIN, 0, 0);
        alu = (op == 5'b00011) ? B_ADD : (op == 5'b00100) ? B_SUB :
              (op == 5'b00101) ? B_AND : B_OR;
        case (op)
            5'b00000, 5'b00001, 5'b00010: begin
                addStep(B_GRB | B_BAOUT | B_YIN, 0, 0);
                addStep(B_COUT | B_ADD | B_ZIN, 0, 0);
                if (op == 5'b00001) begin
                    addStep(B_ZLOW | B_GRA | B_RIN, 0, 0);
                end else begin
                    addStep(B_ZLOW | B_MARIN, 0, 0);
                    if (op == 5'b00000) begin
                        addStep(B_READ | B_MDRIN, 1, 0);
                        addStep(B_MDROUT | B_GRA | B_RIN, 0, 0);
                    end else begin
                        addStep(B_GRA | B_ROUT | B_MDRIN, 0, 0);
                        addStep(B_WRITE, 1, 0);
                    end
                end
            end
            5'b00011, 5'b00100, 5'b00101, 5'b00110: begin
                addStep(B_GRB | B_ROUT | B_YIN, 0, 0);
                addStep(B_GRC | B_ROUT | B_ZIN | alu, 0, 0);
                addStep(B_ZLOW | B_GRA | B_RIN, 0, 0);
            end
            5'b01100: begin
                addStep(B_GRB | B_ROUT | B_YIN, 0, 0);
                addStep(B_COUT | B_ADD | B_ZIN, 0, 0);
                addStep(B_ZLOW | B_GRA | B_RIN, 0, 0);
            end
            5'b10010: begin
                addStep(B_GRA | B_ROUT | B_CONIN, 0, 0);
                addStep(B_PCOUT | B_YIN, 0, 0);
                addStep(B_COUT | B_ADD | B_ZIN, 0, 0);
                addStep(B_ZLOW, 0, 1);
            end
            5'b10100: addStep(B_GRA | B_ROUT | B_PCIN, 0, 0);
            default:  addStep('0, 0, 0);
        endcase
    endtask

    // Runs one instruction from T0. con_mode 0/1 fixes CON_FF, 2 randomizes it;
    // stop_from >= 0 holds Stop high from that step on, otherwise Stop is noise
    // before the final step; abort_at pulls Clear low during that step.
    task automatic applyStimulus(input logic [4:0] op, input int con_mode,
                                 input int stall_fetch, input int stall_mem,
                                 input bit stop_end, input int stop_from,
                                 input int abort_at, input int halt_cycles);
        logic [31:0] ir;
        logic [25:0] exp;
        int n;
        ir = {op, 27'($urandom)};
        buildPlan(op);
        for (int k = 0; k < plan.size(); k++) begin
            n = plan[k].wait_step ? ((k == 1) ? stall_fetch : stall_mem) : 0;
            for (int c = 0; c <= n; c++) begin
                IR = (k < 2) ? $urandom : ir;
                Mem_ready = plan[k].wait_step ? (c == n) : 1'($urandom);
                if (k == plan.size() - 1) Stop = stop_end;
                else Stop = (stop_from >= 0) ? (k >= stop_from) : 1'($urandom);
                CON_FF = (con_mode == 2) ? 1'($urandom) : con_mode[0];
                if (k == abort_at && c == n) Clear = 1'b0;
                #1;
                exp = plan[k].mask | ((plan[k].cond_pc && CON_FF) ? B_PCIN : 26'd0);
                checkOutput($sformatf("op%b_T%0d_c%0d", op, k, c), exp);
                @(posedge Clock); #1;
            end
            if (k == abort_at) begin
                checkOutput($sformatf("reset_mid_op%b", op), '0);
                Clear = 1'b1;
                @(posedge Clock); #1;
                return;
            end
        end
        if (op == 5'b11011 || stop_end) begin
            for (int h = 0; h < halt_cycles; h++) begin
                IR = $urandom;
                Stop = 1'($urandom);
                Mem_ready = 1'($urandom);
                CON_FF = 1'($urandom);
                #1;
                checkOutput($sformatf("halt_op%b_c%0d", op, h), '0);
                @(posedge Clock); #1;
            end
            Clear = 1'b0;
            Stop = 1'b0;
            @(posedge Clock); #1;
            checkOutput("reset_after_halt", '0);
            Clear = 1'b1;
            @(posedge Clock); #1;
        end
    endtask

    initial begin
        int idx;
        repeat (2) @(posedge Clock);
        #1;
        checkOutput("reset", '0);
        Clear = 1'b1;
        @(posedge Clock); #1;

        applyStimulus(5'b00000, 0, 0, 0, 0, -1, -1, 0);
        applyStimulus(5'b11010, 0, 2, 0, 0, -1, -1, 0);
        applyStimulus(5'b00011, 0, 0, 0, 0, -1, -1, 0);
        applyStimulus(5'b00100, 0, 0, 0, 0, -1, -1, 0);
        applyStimulus(5'b00101, 0, 0, 0, 0, -1, -1, 0);
        applyStimulus(5'b00110, 0, 0, 0, 0, -1, -1, 0);
        applyStimulus(5'b10010, 0, 0, 0, 0, -1, -1, 0);
        applyStimulus(5'b10010, 1, 0, 0, 0, -1, -1, 0);
        applyStimulus(5'b11011, 0, 0, 0, 0, -1, -1, 20);
        applyStimulus(5'b00000, 0, 0, 0, 1, 4, -1, 3);
        applyStimulus(5'b00010, 0, 0, 0, 0, -1, 5, 0);
        applyStimulus(5'b00010, 0, 1, 2, 0, -1, -1, 0);

        for (int i = 0; i < 60; i++) begin
            idx = $urandom_range(0, 13);
            applyStimulus(op_list[idx], 2, $urandom_range(0, 2), $urandom_range(0, 2),
                          ($urandom_range(0, 7) == 0), -1,
                          ($urandom_range(0, 9) == 0) ? $urandom_range(0, 3) : -1, 2);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/control_unit.md
# control_unit

Hardwired control sequencer that sits directly upstream of the CPU datapath. It drives every strobe the datapath consumes (bus-source enables, register load enables, ALU operation selects, memory Read/Write) as a Moore function of its step state and the IR opcode. The datapath therefore runs fetch/execute autonomously instead of being driven by a bench. It covers fetch plus the ld, ldi, st, add, sub, and, or, addi, br, jr, nop and halt instructions.

## Interface
Parameters:
- none; opcode and step encodings live in the shared package.

Ports:
- Clock  in  1  system clock; all state changes on the rising edge
- Clear  in  1  reset, synchronous, active-low
- IR  in  32  instruction register contents from the datapath; opcode = IR[31:27]
- CON_FF  in  1  branch condition flip-flop output from the datapath
- Mem_ready  in  1  memory completion; tie high for single-cycle RAM
- Stop  in  1  request halt at the next instruction boundary
- PCout, Zhighout, Zlowout, MDRout  out  1 each  bus source enables
- MARin, Zin, PCin, MDRin, IRin, Yin  out  1 each  register load enables
- IncPC, Read, Write  out  1 each  PC increment, memory read, memory write
- Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONIn  out  1 each  select-and-encode and CON controls
- ADD, SUB, AND, OR  out  1 each  ALU operation selects, one-hot
- Run  out  1  high while executing; low in RESET and HALT

## Operation
- The state register holds one of RESET, T0..T7, HALT. Outputs are a combinational decode of state and opcode. Any signal not listed for a step is 0.
- Fetch steps:
  - T0: PCout, MARin, IncPC, Zin.
  - T1: Zlowout, PCin, Read, MDRin.
  - T2: MDRout, IRin.
- IR becomes valid from T3 onward.
- Opcodes: ld=00000, ldi=00001, st=00010, add=00011, sub=00100, and=00101, or=00110, addi=01100, br=10010, jr=10100, nop=11010, halt=11011. Any undefined opcode executes as nop.
- ld:
  - T3: Grb, BAout, Yin.
  - T4: Cout, ADD, Zin.
  - T5: Zlowout, MARin.
  - T6: Read, MDRin.
  - T7: MDRout, Gra, Rin.
- ldi: T3 and T4 as ld; T5: Zlowout, Gra, Rin.
- st:
  - T3 and T4 as ld.
  - T5: Zlowout, MARin.
  - T6: Gra, Rout, MDRin, with Read=0.
  - T7: Write.
- add, sub, and, or:
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, Zin, plus the matching ALU select.
  - T5: Zlowout, Gra, Rin.
- addi:
  - T3: Grb, Rout, Yin.
  - T4: Cout, ADD, Zin.
  - T5: Zlowout, Gra, Rin.
- br:
  - T3: Gra, Rout, CONIn.
  - T4: PCout, Yin.
  - T5: Cout, ADD, Zin.
  - T6: Zlowout, plus PCin only when CON_FF=1.
- jr: T3: Gra, Rout, PCin.
- nop: T3 asserts nothing.
- halt: T3 asserts nothing, then the next state is HALT.
- After the last step of an instruction, the next state is T0. If Stop=1 at that edge, the next state is HALT instead.
- HALT: all outputs 0, Run=0. It is left only by reset.

## Timing
- Reset:
  - Clear=0 at any rising edge puts the next state in RESET, including mid-instruction.
  - In RESET every output is 0 and Run=0.
  - The first edge with Clear=1 goes to T0.
- Each step lasts one cycle. The datapath captures at the rising edge that ends the step.
- Memory wait steps:
  - The wait steps are T1 (fetch), ld T6 and st T7.
  - In a wait step, the state holds while Mem_ready=0, with all strobes of that step held asserted.
  - The state advances on the first edge with Mem_ready=1.
- Step counts with Mem_ready=1:
  - ld and st: 8 cycles.
  - ldi, add, sub, and, or, addi: 6 cycles.
  - br: 7 cycles.
  - jr, nop, halt: 4 cycles.
- CON_FF is sampled combinationally in br T6.
- Stop is sampled only at the instruction-end edge.
- Exactly one ALU select may be high in any cycle.
- Read and Write are never high together.

## Structure
- Package cpu_ctrl_pkg holds:
  - the opcode localparams;
  - the step state enum (RESET, T0..T7, HALT);
  - the per-opcode last-step table.
- The natural sub-module is ctrl_decode: purely combinational, mapping (state, opcode, CON_FF) to the output vector.
- control_unit holds the state register, next-state logic, Mem_ready stall and Stop/halt handling.

## Test plan
- ld: reset, then IR=0x00800055 with Mem_ready=1. Required response:
  - T0..T7 run in 8 cycles with the exact strobes listed above.
  - T7 asserts MDRout, Gra and Rin.
  - Back in T0 at cycle 9.
- Fetch stall: Mem_ready=0 for 2 cycles in T1. Required response:
  - T1 lasts 3 cycles with Read, MDRin and PCin high throughout.
  - T2 IRin appears only in the 4th cycle.
- add: IR opcode 00011. Required response:
  - T4 asserts Grc, Rout, ADD and Zin.
  - SUB, AND and OR stay 0.
  - T5 asserts Gra and Rin; 6 cycles total.
  - Repeat for sub, and and or: only the matching select is high.
- br: CON_FF=0, then CON_FF=1. Required response:
  - T6 asserts Zlowout in both runs.
  - PCin is high only in the CON_FF=1 run.
- Halt paths:
  - halt opcode: Run drops to 0 after T3 and all outputs stay 0 for 20 cycles.
  - Stop=1 during ld T4: ld completes through T7, then HALT.
- Reset mid-store: Clear=0 during st T5. Required response:
  - Next cycle is RESET with all outputs 0; Write is never asserted.
  - The first edge with Clear=1 goes to T0.
